life_color_scheduler: RTL and testbench



---
 rtl/life_pkg.sv | 13 +
 rtl/raster_counter.sv | 29 ++
 rtl/life_color_scheduler.sv | 111 +++++++++++
 tb/tb_life_color_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared Life grid constants, frame-fill scheduler states and RGB332 field positions.
package life_pkg;
   localparam int GRID_COLS = 128;
   localparam int GRID_ROWS = 96;
   localparam int FB_ADDR_W = 14;
   localparam int RGB_R_MSB = 7;
   localparam int RGB_R_LSB = 5;
   localparam int RGB_G_MSB = 4;
   localparam int RGB_G_LSB = 2;
   localparam int RGB_B_MSB = 1;
   localparam int RGB_B_LSB = 0;
   typedef enum logic [2:0] {IDLE, FETCH, LOOKUP, WRITE, DONE} sched_state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y raster position with last-cell flag; clr restarts at (0,0), adv steps one cell.
module raster_counter #(
   parameter int COLS = 128,
   parameter int ROWS = 96,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         adv,
   output logic [W-1:0] x,
   output logic [W-1:0] y,
   output logic         last
);
   logic x_end;
   assign x_end = x == W'(COLS - 1);
   assign last = x_end && y == W'(ROWS - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (adv) begin
         x <= x_end ? '0 : x + 1'b1;
         y <= x_end ? y + 1'b1 : y;
      end
endmodule

// File: rtl/life_color_scheduler.sv
// life_color_scheduler: raster walk of the Life grid writing one RGB332 pixel per cell to the framebuffer.
// Define FRAME_SWAP_EN for double-buffered output (bank bit as wr_addr MSB plus disp_bank).
module life_color_scheduler
   import life_pkg::*;
#(
   parameter int         COLS       = GRID_COLS,
   parameter int         ROWS       = GRID_ROWS,
   parameter int         ADDR_W     = FB_ADDR_W,
   parameter logic [7:0] DEAD_COLOR = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cell_addr,
   input  logic              cell_alive,
   output logic [7:0]        gen_x,
   output logic [7:0]        gen_y,
   input  logic [7:0]        gen_color,
   output logic              wr_valid,
   input  logic              wr_ready,
`ifdef FRAME_SWAP_EN
   output logic [ADDR_W:0]   wr_addr,
   output logic              disp_bank,
`else
   output logic [ADDR_W-1:0] wr_addr,
`endif
   output logic [7:0]        wr_data
);
   sched_state_t state, state_nx;
   logic [7:0] x, y, gen_x_q, gen_y_q;
   logic last, clr, adv;
   logic [ADDR_W-1:0] addr;
   raster_counter #(.COLS(COLS), .ROWS(ROWS), .W(8)) u_raster (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .adv  (adv),
      .x    (x),
      .y    (y),
      .last (last)
   );
   assign addr = ADDR_W'(y * COLS + x);
   assign cell_addr = addr;
   assign clr = state == IDLE && start;
   assign adv = state == WRITE && wr_ready && !last;
   always_comb begin
      state_nx = state;
      busy = 1'b0;
      done = 1'b0;
      wr_valid = 1'b0;
      gen_x = gen_x_q;
      gen_y = gen_y_q;
      case (state)
         IDLE: state_nx = start ? FETCH : IDLE;
         FETCH: begin
            busy = 1'b1;
            state_nx = LOOKUP;
         end
         LOOKUP: begin
            busy = 1'b1;
            gen_x = x;
            gen_y = y;
            state_nx = WRITE;
         end
         WRITE: begin
            busy = 1'b1;
            wr_valid = 1'b1;
            state_nx = !wr_ready ? WRITE : last ? DONE : FETCH;
         end
         DONE: begin
            done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
`ifdef FRAME_SWAP_EN
   logic bank;
   assign disp_bank = ~bank;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         gen_x_q <= '0;
         gen_y_q <= '0;
         wr_addr <= '0;
         wr_data <= '0;
`ifdef FRAME_SWAP_EN
         bank <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         gen_x_q <= gen_x;
         gen_y_q <= gen_y;
         // cell_alive answers the FETCH-cycle address, so it is valid here in LOOKUP
         if (state == LOOKUP) begin
            wr_data <= cell_alive ? gen_color : DEAD_COLOR;
`ifdef FRAME_SWAP_EN
            wr_addr <= {bank, addr};
`else
            wr_addr <= addr;
`endif
         end
`ifdef FRAME_SWAP_EN
         if (state_nx == DONE && state != DONE)
            bank <= ~bank;
`endif
      end
endmodule

// File: tb/tb_life_color_scheduler.sv
// tb_life_color_scheduler: scoreboard bench; expected pixels are queued at start, a monitor pops them per handshake.
module tb_life_color_scheduler;
   import life_pkg::*;
   localparam int N = GRID_COLS * GRID_ROWS;
`ifdef FRAME_SWAP_EN
   localparam int WA = 15;
`else
   localparam int WA = 14;
`endif
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cell_alive = 1'b0, wr_ready = 1'b1, live_en = 1'b0;
   logic busy, done, wr_valid;
   logic [13:0] cell_addr;
   logic [7:0] gen_x, gen_y, gen_color, wr_data;
   logic [WA-1:0] wr_addr;
`ifdef FRAME_SWAP_EN
   logic disp_bank;
`endif
   int errors = 0, checks = 0, cyc = 0, s_cyc = 0, len = 0, dn = 0, wv = 0;
   logic [WA-1:0] exp_a[$];
   logic [7:0] exp_d[$];

   life_color_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .cell_addr (cell_addr),
      .cell_alive(cell_alive),
      .gen_x     (gen_x),
      .gen_y     (gen_y),
      .gen_color (gen_color),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
`ifdef FRAME_SWAP_EN
      .disp_bank (disp_bank),
`endif
      .wr_data   (wr_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // cell memory: only (127,95) alive when live_en, one-cycle read latency
   always @(posedge clk) cell_alive <= live_en && cell_addr == 14'd12287;
   // color generator stand-in: (127,95) -> 7F ^ F5 = 8A
   assign gen_color = gen_x ^ {gen_y[3:0], gen_y[7:4]};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_frame(input int bnk, input bit live);
      for (int i = 0; i < N; i++) begin
         exp_a.push_back(WA'(i) | (WA'(bnk) << 14));
         exp_d.push_back(live && i == N - 1 ? 8'h8A : 8'h00);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      s_cyc = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_write(input int a);
      int n = 0;
      while (!(wr_valid && wr_addr[13:0] == 14'(a)) && n < 40000) begin
         step();
         n++;
      end
      if (n == 40000) begin
         checks++;
         errors++;
         $display("FAIL wait_write timeout: write %0d never presented", a);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 40000) begin
         step();
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL wait_done timeout: done not seen");
      end
      len = cyc - s_cyc;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " wr_valid"}, wr_valid, 0);
      chk({tag, " wr_addr"}, wr_addr, 0);
      chk({tag, " wr_data"}, wr_data, 0);
      chk({tag, " cell_addr"}, cell_addr, 0);
      chk({tag, " gen_x"}, gen_x, 0);
      chk({tag, " gen_y"}, gen_y, 0);
   endtask

   always @(negedge clk)
      if (rst_n && wr_valid && wr_ready) begin
         if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected write: addr %0h data %0h, none expected", wr_addr, wr_data);
         end else begin
            chk("wr_addr", wr_addr, exp_a.pop_front());
            chk("wr_data", wr_data, exp_d.pop_front());
         end
      end

   initial begin
      #3;
      chk_reset("reset");
      step();
      rst_n = 1'b1;
      step();
      step();
      // frame 1: all dead, wr_ready always high
      push_frame(0, 0);
      pulse_start();
      chk("busy after start", busy, 1);
      step();
      chk("wr_valid at +2", wr_valid, 0);
      step();
      chk("wr_valid at +3", wr_valid, 1);
      wait_done();
      chk("frame1 length", len, 36865);
      chk("busy at done", busy, 0);
`ifdef FRAME_SWAP_EN
      chk("disp_bank after frame1", disp_bank, 0);
`endif
      step();
      chk("done one cycle", done, 0);
      chk("queue drained 1", exp_a.size(), 0);
      chk("gen_x held", gen_x, 127);
      chk("gen_y held", gen_y, 95);
      // frame 2: last cell alive, 5-cycle stall on write 9, stray start mid-frame
      live_en = 1'b1;
      push_frame(1, 1);
      pulse_start();
      wait_write(9);
      wr_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall wr_valid", wr_valid, 1);
         chk("stall wr_addr", wr_addr[13:0], 9);
         chk("stall wr_data", wr_data, 0);
      end
      wr_ready = 1'b1;
      wait_write(100);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy through stray start", busy, 1);
      wait_done();
      chk("frame2 length", len, 36870);
`ifdef FRAME_SWAP_EN
      chk("disp_bank after frame2", disp_bank, 1);
`endif
      dn = 0;
      wv = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         dn += int'(done);
         wv += int'(wr_valid);
      end
      chk("extra done", dn, 0);
      chk("restart writes", wv, 0);
      chk("queue drained 2", exp_a.size(), 0);
      chk("gen_x held 2", gen_x, 127);
      chk("gen_y held 2", gen_y, 95);
      // frame 3: asynchronous reset at write 500
      live_en = 1'b0;
      push_frame(0, 0);
      pulse_start();
      wait_write(500);
      rst_n = 1'b0;
      #1;
      chk_reset("abort");
      chk("writes before abort", exp_a.size(), N - 500);
      exp_a.delete();
      exp_d.delete();
      step();
      rst_n = 1'b1;
      step();
      // frame 4: restart must begin at address 0
      push_frame(0, 0);
      pulse_start();
      wait_write(20);
      chk("writes after restart", exp_a.size(), N - 20);
      rst_n = 1'b0;
      #1;
      exp_a.delete();
      exp_d.delete();
      step();
      rst_n = 1'b1;
      step();
      chk("idle after final reset", busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
